// File: rtl/direct_mapped_cache_if.sv
// +--------------------------------------------------------------------+
// | direct_mapped_cache_if : Avalon-MM word bus for the CPU/memory side |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface direct_mapped_cache_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  logic [31:0]           writedata;
  logic [3:0]            byteenable;
  logic                  waitrequest;
  logic [31:0]           readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

`default_nettype wire

// File: rtl/direct_mapped_cache.sv
// +--------------------------------------------------------------------+
// | direct_mapped_cache : write-through, no-write-allocate, 1 word/line |
// | Optional macro CACHE_STATS_EN adds hit_count/miss_count. Rev 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module direct_mapped_cache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             flush,
  direct_mapped_cache_if.slave  cpu,
  direct_mapped_cache_if.master mem
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_t;

  state_t                state;
  state_t                state_next;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];
  logic                  flush_pending;
  logic                  fill_serve;
  logic                  done;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] word_address;

  assign index        = cpu.address[INDEX_BITS+1:2];
  assign tag          = cpu.address[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit          = valid[index] && (tag_mem[index] == tag);
  assign word_address = cpu.address & ~(ADDR_WIDTH'(3));

  always_comb begin
    state_next      = state;
    done            = 1'b0;
    cpu.waitrequest = 1'b0;
    cpu.readdata    = 32'd0;
    mem.read        = 1'b0;
    mem.write       = 1'b0;
    mem.address     = '0;
    mem.writedata   = 32'd0;
    mem.byteenable  = 4'd0;
    if (!reset) begin
      cpu.waitrequest = 1'b1;
      state_next      = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // The cycle after a fill serves from the array even if a flush
          // has since invalidated the line.
          if (fill_serve && cpu.read && !cpu.write) begin
            cpu.readdata = data_mem[index];
          end else if (cpu.write) begin
            cpu.waitrequest = 1'b1;
            state_next      = WRITE;
          end else if (cpu.read) begin
            if (hit && !flush) begin
              cpu.readdata = data_mem[index];
            end else begin
              cpu.waitrequest = 1'b1;
              state_next      = FILL;
            end
          end
        end
        FILL: begin
          cpu.waitrequest = 1'b1;
          mem.read        = 1'b1;
          mem.address     = word_address;
          mem.byteenable  = 4'b1111;
          if (!mem.waitrequest) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
        WRITE: begin
          mem.write       = 1'b1;
          mem.address     = word_address;
          mem.writedata   = cpu.writedata;
          mem.byteenable  = cpu.byteenable;
          cpu.waitrequest = mem.waitrequest;
          if (!mem.waitrequest) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      valid         <= '0;
      flush_pending <= 1'b0;
      fill_serve    <= 1'b0;
    end else begin
      state      <= state_next;
      fill_serve <= (state == FILL) && done;
      if (done) begin
        flush_pending <= 1'b0;
        if (state == FILL) valid[index] <= 1'b1;
        // A flush seen during the transaction wins over the fill just made.
        if (flush_pending || flush) valid <= '0;
      end else if (flush) begin
        if (state == IDLE) valid <= '0;
        else flush_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && done) begin
      if (state == FILL) begin
        data_mem[index] <= mem.readdata;
        tag_mem[index]  <= tag;
      end else if (hit) begin
        for (int b = 0; b < 4; b++) begin
          if (cpu.byteenable[b]) data_mem[index][8*b +: 8] <= cpu.writedata[8*b +: 8];
        end
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic hit_event;
  logic miss_event;

  assign hit_event  = reset && (state == IDLE) && !fill_serve && cpu.read &&
                      !cpu.write && hit && !flush;
  assign miss_event = reset && (state == IDLE) && (state_next == FILL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit_event)  hit_count  <= hit_count + 32'd1;
      if (miss_event) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_direct_mapped_cache.sv
// Scoreboard bench: the driver pushes expectations from an abstract cache
// model, a negedge monitor pops and compares whenever the CPU is released.
`default_nettype none

module tb_direct_mapped_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic flush;

  direct_mapped_cache_if #(.ADDR_WIDTH(32)) cpu_bus ();
  direct_mapped_cache_if #(.ADDR_WIDTH(32)) mem_bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  direct_mapped_cache #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .cpu        (cpu_bus.slave),
    .mem        (mem_bus.master)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Abstract model: backing memory plus one {valid, tag, data} per index.
  logic [31:0] ref_mem  [256];
  bit          ref_valid[64];
  logic [23:0] ref_tag  [64];
  logic [31:0] ref_data [64];
  int          ref_hits;
  int          ref_misses;
  int          mem_wait_cfg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic ref_invalidate();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
  endtask

  // Memory slave: mem_wait_cfg wait cycles, then one completion cycle.
  logic [31:0] mem_arr[256];
  bit          mem_loaded = 1'b0;
  bit          resp_active = 1'b0;
  int          resp_cnt;
  always @(posedge clk) begin
    #2;
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem_arr[i] = ref_mem[i];
      mem_loaded = 1'b1;
    end
    if (mem_bus.read || mem_bus.write) begin
      if (!resp_active) begin
        resp_active = 1'b1;
        resp_cnt    = mem_wait_cfg;
      end
      if (resp_cnt == 0) begin
        mem_bus.waitrequest = 1'b0;
        if (mem_bus.read) begin
          mem_bus.readdata = mem_arr[mem_bus.address[9:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (mem_bus.byteenable[b])
              mem_arr[mem_bus.address[9:2]][8*b +: 8] = mem_bus.writedata[8*b +: 8];
        end
        resp_active = 1'b0;
      end else begin
        mem_bus.waitrequest = 1'b1;
        resp_cnt--;
      end
    end else begin
      resp_active         = 1'b0;
      mem_bus.waitrequest = 1'b1;
      mem_bus.readdata    = $urandom;
    end
  end

  int stall = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      stall = 0;
    end else begin
      if (mem_bus.read && mem_bus.write) check("mem_rd_wr_exclusive", 32'd1, 32'd0);
      if ((mem_bus.read || mem_bus.write) && !mem_bus.waitrequest && exp_q.size() > 0) begin
        check("mem_address", mem_bus.address, exp_q[0].addr & 32'hFFFF_FFFC);
        check("mem_byteenable", {28'd0, mem_bus.byteenable},
              {28'd0, exp_q[0].is_wr ? exp_q[0].be : 4'hF});
        check("mem_cmd_kind", {31'd0, mem_bus.write}, {31'd0, exp_q[0].is_wr});
        if (mem_bus.write) check("mem_writedata", mem_bus.writedata, exp_q[0].data);
      end
      if (cpu_bus.read || cpu_bus.write) begin
        if (cpu_bus.waitrequest) begin
          stall++;
        end else if (exp_q.size() == 0) begin
          check("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stall_cycles", stall, e.stall);
          if (!e.is_wr) check("cpu_readdata", cpu_bus.readdata, e.data);
          stall = 0;
        end
      end else begin
        check("idle_waitrequest", {31'd0, cpu_bus.waitrequest}, 32'd0);
      end
    end
  end

  task automatic reset_checks();
    check("rst_waitrequest", {31'd0, cpu_bus.waitrequest}, 32'd1);
    check("rst_readdata",    cpu_bus.readdata, 32'd0);
    check("rst_mem_read",    {31'd0, mem_bus.read}, 32'd0);
    check("rst_mem_write",   {31'd0, mem_bus.write}, 32'd0);
    check("rst_mem_address", mem_bus.address, 32'd0);
    check("rst_mem_wdata",   mem_bus.writedata, 32'd0);
    check("rst_mem_be",      {28'd0, mem_bus.byteenable}, 32'd0);
  endtask

  // flush_sel: 0 none, 1 with the request, 2 at a random later stall cycle.
  task automatic issue(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int waits, input int flush_sel);
    exp_t        e;
    int          idx;
    int          word;
    int          flush_at;
    int          cyc;
    bit          hit;
    bit          wr;
    idx  = int'(addr[7:2]);
    word = int'(addr[9:2]);
    if (flush_sel == 1) ref_invalidate();
    hit = ref_valid[idx] && (ref_tag[idx] == addr[31:8]);
    e.is_wr = is_wr;
    e.addr  = addr;
    e.be    = be;
    if (is_wr) begin
      e.stall = waits + 1;
      e.data  = wd;
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          ref_mem[word][8*b +: 8] = wd[8*b +: 8];
          if (hit) ref_data[idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end else if (hit) begin
      e.stall = 0;
      e.data  = ref_data[idx];
      ref_hits++;
    end else begin
      e.stall        = waits + 2;
      e.data         = ref_mem[word];
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = addr[31:8];
      ref_data[idx]  = ref_mem[word];
      ref_misses++;
    end
    flush_at = -1;
    if (flush_sel == 1) flush_at = 0;
    else if (flush_sel == 2 && e.stall > 0) flush_at = $urandom_range(1, e.stall);
    if (flush_at >= 0) ref_invalidate();
    exp_q.push_back(e);

    mem_wait_cfg          = waits;
    cpu_bus.address       = addr;
    cpu_bus.write         = is_wr;
    cpu_bus.read          = !is_wr || also_rd;
    cpu_bus.writedata     = wd;
    cpu_bus.byteenable    = be;
    cyc = 0;
    forever begin
      flush = (cyc == flush_at);
      @(negedge clk);
      wr = cpu_bus.waitrequest;
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (!wr) break;
      cyc++;
      if (cyc > 200) begin
        check("request_timeout", 32'd1, 32'd0);
        break;
      end
    end
    cpu_bus.read  = 1'b0;
    cpu_bus.write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input int waits, input int flush_sel);
    issue(1'b0, 1'b0, addr, 32'd0, 4'd0, waits, flush_sel);
  endtask

  task automatic stats_check();
`ifdef CACHE_STATS_EN
    @(negedge clk);
    check("hit_count",  hit_count,  ref_hits);
    check("miss_count", miss_count, ref_misses);
    @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b0;
    flush = 1'b0;
    cpu_bus.read       = 1'b0;
    cpu_bus.write      = 1'b0;
    cpu_bus.address    = 32'd0;
    cpu_bus.writedata  = 32'd0;
    cpu_bus.byteenable = 4'd0;
    mem_wait_cfg       = 0;
    ref_hits           = 0;
    ref_misses         = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[8'h40] = 32'hDEADBEEF;
    ref_invalidate();

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    rd(32'h0000_0100, 3, 0);                                  // cold miss, 5-cycle stall
    rd(32'h0000_0100, 3, 0);                                  // zero-wait hit
    stats_check();
    issue(1'b1, 1'b0, 32'h0000_0100, 32'h0000_00AA, 4'b0001, 1, 0);
    rd(32'h0000_0100, 2, 0);                                  // 0xDEADBEAA from the line
    rd(32'h0000_0200, 1, 0);
    rd(32'h0000_0100, 0, 0);                                  // evicted by the conflict
    rd(32'h0000_0300, 3, 2);                                  // flush mid-fill
    rd(32'h0000_0300, 1, 0);
    issue(1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 4'b1010, 2, 0);
    rd(32'h0000_0104, 0, 1);                                  // flush with the request

    // Reset in the middle of a stalled write.
    mem_wait_cfg       = 10;
    cpu_bus.address    = 32'h0000_0100;
    cpu_bus.writedata  = 32'h1234_5678;
    cpu_bus.byteenable = 4'hF;
    cpu_bus.write      = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mem_write_before_reset", {31'd0, mem_bus.write}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cpu_bus.write = 1'b0;
    ref_invalidate();
    ref_hits   = 0;
    ref_misses = 0;
    @(negedge clk);
    check("mem_write_after_reset", {31'd0, mem_bus.write}, 32'd0);
    @(posedge clk);
    #1;
    rd(32'h0000_0100, 1, 0);
    rd(32'h0000_0300, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int  sel;
      int  r;
      bit  w;
      a = {($urandom_range(0, 7) == 0), 21'd0, 8'($urandom), 2'($urandom)};
      r = $urandom_range(0, 9);
      sel = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) begin
        flush = 1'b1;
        ref_invalidate();
        @(posedge clk);
        #1;
        flush = 1'b0;
      end
      issue(w, w && ($urandom_range(0, 3) == 0), a, $urandom, 4'($urandom),
            $urandom_range(0, 3), sel);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    stats_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
